// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags, sticky error flags
// and a selectable first-word-fall-through read mode.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd_inc,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full_flag,
  output logic                  empty_flag,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           fill_count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_count;
  logic r_overflow, r_underflow, w_wr_acc, w_rd_acc;
  // the extra pointer bit lets the plain difference distinguish full from empty
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign fill_count = w_count;
  assign full_flag = w_count == (AW+1)'(DEPTH);
  assign empty_flag = w_count == '0;
  assign almost_full = w_count >= (AW+1)'(AF_LEVEL);
  assign almost_empty = w_count <= (AW+1)'(AE_LEVEL);
  assign w_wr_acc = w_inc && !full_flag;
  assign w_rd_acc = rd_inc && !empty_flag;
  assign overflow = r_overflow;
  assign underflow = r_underflow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_overflow <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_wr_acc);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_rd_acc);
      r_overflow <= (w_inc && full_flag) || (r_overflow && !clr_err);
      r_underflow <= (rd_inc && empty_flag) || (r_underflow && !clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) r_mem[r_wr_ptr[AW-1:0]] <= w_data;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk) begin
        if (rst) r_rd_data <= '0;
        else if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
      assign rd_data = r_rd_data;
    end
  endgenerate
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of our FIFO family. It generalises data width and depth, and adds several features:
- almost-full / almost-empty thresholds, a live fill count and sticky overflow/underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It buffers data between producer and consumer logic sharing one clock domain, in place of the dual-clock FIFO wherever no crossing exists.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- DEPTH, 16, number of entries; power of two, >= 2
- AF_LEVEL, 14, almost_full asserted when fill_count >= AF_LEVEL; 1..DEPTH
- AE_LEVEL, 2, almost_empty asserted when fill_count <= AE_LEVEL; 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports (AW = $clog2(DEPTH)):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_inc  in  1  write request
- w_data  in  DATA_WIDTH  write word
- rd_inc  in  1  read request
- rd_data  out  DATA_WIDTH  read word
- full_flag  out  1  fill_count == DEPTH
- empty_flag  out  1  fill_count == 0
- almost_full  out  1  fill_count >= AF_LEVEL
- almost_empty  out  1  fill_count <= AE_LEVEL
- fill_count  out  AW+1  number of stored words, 0..DEPTH
- clr_err  in  1  clears overflow/underflow
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
Pointers:
- wr_ptr and rd_ptr are AW+1-bit binary pointers.
- Memory index is ptr[AW-1:0]; the pointers wrap naturally modulo 2*DEPTH.
- fill_count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).

Accepting requests:
- A write is accepted iff w_inc && !full_flag. It stores w_data at mem[wr_ptr] and increments wr_ptr.
- A read is accepted iff rd_inc && !empty_flag. It increments rd_ptr.
- Flags are evaluated on the pre-edge state. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write leaves fill_count unchanged.

Read modes:
- FWFT=0: on an accepted read, rd_data <= mem[rd_ptr] at that edge. rd_data holds its value otherwise, including across rejected reads.
- FWFT=1: rd_data = mem[rd_ptr[AW-1:0]] combinationally whenever !empty_flag; rd_inc acknowledges and pops that word. When empty, rd_data is undefined and the bench does not check it.

Error flags:
- overflow is set on w_inc && full_flag; underflow is set on rd_inc && empty_flag.
- Both are cleared by clr_err or rst. If set and clear occur in the same cycle, set wins.

Reset:
- Memory is not reset.
- Reset mid-operation discards all contents: pointers go to 0 and any in-flight request in the reset cycle is ignored.

## Timing
Reset values (after the rst edge):
- empty_flag=1, full_flag=0, almost_empty=1, fill_count=0, overflow=0, underflow=0.
- almost_full=0 (AF_LEVEL >= 1 guarantees this).
- rd_data=0 in FWFT=0 mode.

Latency:
- Flags, fill_count and error flags are registered, or decoded from registered pointers only. They update at the edge that accepts the request and are visible in the following cycle.
- Write to readable: a write accepted at edge N deasserts empty_flag after edge N. In FWFT=1 the word appears on rd_data after edge N; in FWFT=0 it can first be popped at edge N+1 and appears after that edge.
- Read: FWFT=0 has 1-cycle latency from an accepted rd_inc to rd_data. FWFT=1 has 0-cycle latency, and the next word appears after the popping edge.

Throughput and stability:
- Full throughput: one write and one read per cycle, sustained indefinitely.
- No combinational path from w_inc or rd_inc to any output.

## Test plan
- Reset, then 16 writes of 1..16 (DEPTH=16) -> full_flag=1 after the 16th edge, fill_count=16, almost_full=1 from count 14. A 17th write (0xAA) -> overflow=1, contents unchanged.
- Read 16 words from the full FIFO (FWFT=0) -> rd_data 1..16 in order, each one cycle after its rd_inc edge. empty_flag=1 after the 16th read. A further rd_inc -> underflow=1 and rd_data holds 16.
- Wrap-around: write 10, read 10, then write/read 40 words of 0x30.. continuously -> data in order across the pointer wrap, and fill_count never exceeds its expected value.
- Simultaneous operations:
  - w_inc && rd_inc at fill_count=5 -> count stays 5.
  - Both requests while empty -> write only, count=1, underflow=1.
  - Both requests while full -> read only, count=15, overflow=1.
- FWFT=1: write 0x11 at edge N -> rd_data=0x11 and empty_flag=0 after edge N. Pop -> empty_flag=1 the next cycle.
- rst asserted with fill_count=9 and pending w_inc -> all outputs at reset values next cycle, fill_count=0. clr_err together with overflow set -> overflow stays 1 only if w_inc && full in that same cycle.
